// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and state type for the BK keyboard controller
package kbd_pkg;
  localparam logic [15:0] ADDR_CSR = 16'o177660;
  localparam logic [15:0] ADDR_DATA = 16'o177662;
  localparam int RDY_BIT = 7;
  localparam int IE_N_BIT = 6;
  localparam int OVF_CLR_BIT = 0;
  localparam logic [8:0] VEC_KEY_DEF = 9'o060;
  localparam logic [8:0] VEC_AR2_DEF = 9'o274;
  typedef enum logic [1:0] {IDLE, REQ, SERVED} state_e;
endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: ring-buffer FIFO that keeps one slot free, so it holds DEPTH-1 entries
module kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign empty = wp_q == rp_q;
  assign full = (wp_q + AW'(1)) == rp_q;
  // the spare slot lets a push land even when full, as long as a pop frees one
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign dout = mem_q[rp_q];
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q <= wp_q + AW'(1);
      end
      if (do_pop) rp_q <= rp_q + AW'(1);
    end
  end
endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: BK keyboard CSR/DATA register pair with type-ahead buffer and vectored interrupt
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter logic [8:0] VEC_KEY = VEC_KEY_DEF,
  parameter logic [8:0] VEC_AR2 = VEC_AR2_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        key_stb,
  input  logic [6:0]  key_code,
  input  logic        key_ar2,
  input  logic        key_down,
  input  logic        bus_csr_sel,
  input  logic        bus_data_sel,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        irq,
  output logic [8:0]  irq_vec,
  input  logic        irq_ack,
  output logic        key_held_n,
  output logic        ovf
);
  logic rdy_q, rdy_d, ie_n_q, ie_n_d, ar2_q, ovf_q, ovf_d, held_n_q;
  logic [6:0] data_q;
  state_e state_q, state_d;
  logic push, pop, full, empty, csr_wr, data_rd, rd_clr;
  logic [7:0] head;
  logic [15:0] csr;
  wire unused = ^{bus_din, bus_data_sel & bus_wr};
  assign push = key_stb & |key_code;
  assign pop = ~rdy_q & ~empty;
  assign csr_wr = bus_csr_sel & bus_wr;
  assign data_rd = bus_data_sel & bus_rd & ~bus_csr_sel;
  assign rd_clr = data_rd & rdy_q;
  assign rdy_d = pop ? 1'b1 : rd_clr ? 1'b0 : rdy_q;
  assign ie_n_d = csr_wr ? bus_din[IE_N_BIT] : ie_n_q;
  assign ovf_d = (push & full & ~pop) | (ovf_q & ~(csr_wr & bus_din[OVF_CLR_BIT]));
  kbd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk_sys(clk_sys),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({key_ar2, key_code}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // next-state uses ie_n_d so a CSR write takes effect on the same edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rdy_q & ~ie_n_d & ~rd_clr) state_d = REQ;
      REQ: state_d = irq_ack ? SERVED : (ie_n_d | rd_clr) ? IDLE : REQ;
      SERVED: if (~rdy_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rdy_q <= 1'b0;
      ie_n_q <= 1'b0;
      ar2_q <= 1'b0;
      data_q <= '0;
      ovf_q <= 1'b0;
      held_n_q <= 1'b1;
      state_q <= IDLE;
    end else begin
      rdy_q <= rdy_d;
      ie_n_q <= ie_n_d;
      ovf_q <= ovf_d;
      held_n_q <= ~key_down;
      state_q <= state_d;
      if (pop) {ar2_q, data_q} <= head;
    end
  end
  always_comb begin
    csr = '0;
    csr[RDY_BIT] = rdy_q;
    csr[IE_N_BIT] = ie_n_q;
  end
  assign bus_dout = bus_csr_sel ? csr : bus_data_sel ? {9'b0, data_q} : '0;
  assign irq = state_q == REQ;
  assign irq_vec = ar2_q ? VEC_AR2 : VEC_KEY;
  assign key_held_n = held_n_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_kbd_ctrl.sv
// tb_kbd_ctrl: table-driven key strokes with a key scoreboard, plus overflow, masking and reset sequences
module tb_kbd_ctrl;
  localparam int DEPTH = 4;
  logic clk_sys = 0, reset = 1, key_stb = 0, key_ar2 = 0, key_down = 0;
  logic bus_csr_sel = 0, bus_data_sel = 0, bus_rd = 0, bus_wr = 0, irq_ack = 0;
  logic [6:0] key_code = 0;
  logic [15:0] bus_din = 0, bus_dout, v;
  logic irq, key_held_n, ovf;
  logic [8:0] irq_vec;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic exp_ovf = 0;
  typedef struct {logic [6:0] code; logic ar2; logic ack; logic [8:0] vec;} vec_t;
  vec_t tbl[4];

  kbd_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset(reset), .key_stb(key_stb), .key_code(key_code),
    .key_ar2(key_ar2), .key_down(key_down), .bus_csr_sel(bus_csr_sel),
    .bus_data_sel(bus_data_sel), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_din(bus_din),
    .bus_dout(bus_dout), .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .key_held_n(key_held_n), .ovf(ovf)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic peek_csr(output logic [15:0] r);
    bus_csr_sel = 1;
    #1 r = bus_dout;
    bus_csr_sel = 0;
  endtask

  task automatic stroke(input logic [6:0] c, input logic a);
    key_code = c;
    key_ar2 = a;
    key_stb = 1;
    if (c != 0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({a, c});
      else exp_ovf = 1;
    end
    tick();
    key_stb = 0;
    key_code = 0;
    key_ar2 = 0;
  endtask

  task automatic data_rd(input string name);
    logic [15:0] r;
    logic [7:0] e;
    bus_data_sel = 1;
    bus_rd = 1;
    @(negedge clk_sys);
    r = bus_dout;
    @(posedge clk_sys);
    #1;
    bus_data_sel = 0;
    bus_rd = 0;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h expected nothing (scoreboard empty)", name, r);
    end else begin
      e = exp_q.pop_front();
      check(name, r, {9'b0, e[6:0]});
    end
  endtask

  task automatic csr_wr(input logic [15:0] d);
    bus_csr_sel = 1;
    bus_wr = 1;
    bus_din = d;
    tick();
    bus_csr_sel = 0;
    bus_wr = 0;
    bus_din = 0;
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (!irq && n < 20) begin
      tick();
      n++;
    end
    check(name, irq, 1);
  endtask

  task automatic wait_rdy(input string name);
    logic [15:0] r;
    int n = 0;
    peek_csr(r);
    while (!r[7] && n < 20) begin
      tick();
      peek_csr(r);
      n++;
    end
    check(name, r[7], 1);
  endtask

  initial begin
    tbl[0] = '{7'h61, 1'b0, 1'b1, 9'o060};
    tbl[1] = '{7'o023, 1'b1, 1'b0, 9'o274};
    tbl[2] = '{7'h7f, 1'b1, 1'b1, 9'o274};
    tbl[3] = '{7'h01, 1'b0, 1'b0, 9'o060};
    tick(2);
    peek_csr(v);
    check("reset_csr", v, 16'h0000);
    check("reset_irq", irq, 0);
    check("reset_vec", irq_vec, 9'o060);
    check("reset_held_n", key_held_n, 1);
    check("reset_ovf", ovf, 0);
    reset = 0;
    tick();
    bus_data_sel = 1;
    #1 check("reset_data", bus_dout, 16'h0000);
    bus_data_sel = 0;
    for (int i = 0; i < 4; i++) begin
      stroke(tbl[i].code, tbl[i].ar2);
      peek_csr(v);
      check("rdy_first_clock", v, 16'h0000);
      tick();
      peek_csr(v);
      check("rdy_second_clock", v, 16'h0080);
      wait_irq("irq_rise");
      check("irq_vec", irq_vec, tbl[i].vec);
      if (tbl[i].ack) begin
        irq_ack = 1;
        tick();
        irq_ack = 0;
        check("irq_ack_drop", irq, 0);
        tick(3);
        check("served_quiet", irq, 0);
      end
      data_rd("data_read");
      check("irq_after_read", irq, 0);
      peek_csr(v);
      check("rdy_cleared", v, 16'h0000);
      tick(4);
      check("no_second_irq", irq, 0);
    end
    for (int i = 0; i < 5; i++) stroke(7'h61 + 7'(i), 1'b0);
    tick();
    check("ovf_set", ovf, exp_ovf);
    for (int i = 0; i < 4; i++) begin
      wait_rdy("ovf_rdy");
      data_rd("ovf_read");
    end
    tick(4);
    peek_csr(v);
    check("dropped_key_absent", v[7], 0);
    csr_wr(16'h0001);
    exp_ovf = 0;
    check("ovf_clear", ovf, exp_ovf);
    csr_wr(16'h0040);
    stroke(7'h41, 1'b0);
    wait_rdy("masked_rdy");
    peek_csr(v);
    check("masked_csr", v, 16'h00c0);
    tick(3);
    check("masked_irq", irq, 0);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    csr_wr(16'h0000);
    check("unmask_irq", irq, 1);
    check("unmask_vec", irq_vec, 9'o060);
    data_rd("unmask_read");
    check("unmask_irq_drop", irq, 0);
    stroke(7'h00, 1'b1);
    tick(4);
    peek_csr(v);
    check("code0_csr", v, 16'h0000);
    check("code0_irq", irq, 0);
    key_down = 1;
    tick();
    check("held_n_low", key_held_n, 0);
    key_down = 0;
    tick();
    check("held_n_high", key_held_n, 1);
    stroke(7'h31, 1'b1);
    stroke(7'h32, 1'b0);
    stroke(7'h33, 1'b0);
    wait_irq("pre_reset_irq");
    key_down = 1;
    tick();
    reset = 1;
    tick();
    check("midreset_irq", irq, 0);
    check("midreset_vec", irq_vec, 9'o060);
    check("midreset_held_n", key_held_n, 1);
    peek_csr(v);
    check("midreset_csr", v, 16'h0000);
    exp_q.delete();
    reset = 0;
    key_down = 0;
    tick(5);
    peek_csr(v);
    check("fifo_flushed", v, 16'h0000);
    check("post_reset_irq", irq, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
